// File: rtl/gf_exp_ctrl.sv
// GF(2^m) exponentiation controller: left-to-right square-and-multiply driving an external
// registered multiplier. Define EXP_SKIP_LZ_EN to skip leading zero exponent bits via SCAN.
module gf_exp_ctrl #(
  parameter int unsigned m   = 16,
  parameter int unsigned E_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [m-1:0]   a_in,
  input  logic [E_W-1:0] e_in,
  output logic           busy,
  output logic           done,
  output logic [m-1:0]   c_out,
  output logic [m-1:0]   mul_a,
  output logic [m-1:0]   mul_b,
  input  logic [m-1:0]   mul_c
);

  localparam int unsigned BitW = (E_W > 1) ? $clog2(E_W) : 1;
  localparam logic [m-1:0] One = {{(m-1){1'b0}}, 1'b1};
  localparam logic [BitW-1:0] TopBit = BitW'(E_W - 1);

`ifdef EXP_SKIP_LZ_EN
  typedef enum logic [2:0] {
    StIdle, StSqIss, StSqWb, StMulIss, StMulWb, StDone, StScan
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StSqIss, StSqWb, StMulIss, StMulWb, StDone
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [m-1:0]    acc_q, acc_d;
  logic [m-1:0]    a_q, a_d;
  logic [E_W-1:0]  e_q, e_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [m-1:0]    c_out_q, c_out_d;
  logic            last_bit;
  logic            cur_bit;

  assign last_bit = (bit_q == '0);
  assign cur_bit  = e_q[bit_q];
  assign c_out    = c_out_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    e_d     = e_q;
    bit_d   = bit_q;
    c_out_d = c_out_q;
    mul_a   = '0;
    mul_b   = '0;
    done    = 1'b0;
    busy    = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d   = a_in;
          e_d   = e_in;
          acc_d = One;
          bit_d = TopBit;
`ifdef EXP_SKIP_LZ_EN
          state_d = StScan;
`else
          state_d = StSqIss;
`endif
        end
      end
`ifdef EXP_SKIP_LZ_EN
      // acc is still 1 here, so squaring it would be wasted work.
      StScan: begin
        if (cur_bit) begin
          state_d = StMulIss;
        end else if (last_bit) begin
          state_d = StDone;
        end else begin
          bit_d = bit_q - BitW'(1);
        end
      end
`endif
      StSqIss: begin
        mul_a   = acc_q;
        mul_b   = acc_q;
        state_d = StSqWb;
      end
      StSqWb: begin
        mul_a = acc_q;
        mul_b = acc_q;
        acc_d = mul_c;
        if (cur_bit) begin
          state_d = StMulIss;
        end else if (last_bit) begin
          state_d = StDone;
        end else begin
          bit_d   = bit_q - BitW'(1);
          state_d = StSqIss;
        end
      end
      StMulIss: begin
        mul_a   = acc_q;
        mul_b   = a_q;
        state_d = StMulWb;
      end
      StMulWb: begin
        mul_a = acc_q;
        mul_b = a_q;
        acc_d = mul_c;
        if (last_bit) begin
          state_d = StDone;
        end else begin
          bit_d   = bit_q - BitW'(1);
          state_d = StSqIss;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Capture the final accumulator on entry to DONE so c_out is valid alongside done.
    if (state_d == StDone && state_q != StDone) begin
      c_out_d = acc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= One;
      a_q     <= '0;
      e_q     <= '0;
      bit_q   <= TopBit;
      c_out_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      e_q     <= e_d;
      bit_q   <= bit_d;
      c_out_q <= c_out_d;
    end
  end

endmodule
